fixed_mult: RTL and testbench

- Fixed-point multiply stage that feeds the adder stage in the datapath.
- Pops one operand from each of two first-word-fall-through input FIFOs and forms the signed product.
- Dequantizes the product by FRAC_BITS and pushes it to an output FIFO that the adder's operand path reads.
- Three-stage register pipeline; one result per cycle sustained; full backpressure from the output FIFO.

---
 rtl/fixed_mult_if.sv | 25 ++
 rtl/fixed_mult.sv | 104 ++++++++++
 tb/tb_fixed_mult.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_mult_if.sv
// FIFO-side bundle for fixed_mult: two operand read ports and one result write port.
// master = FIFO/environment side, slave = multiply stage.
interface fixed_mult_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  in_a_empty;
  logic [DATA_WIDTH-1:0] in_a_dout;
  logic                  in_a_rd_en;
  logic                  in_b_empty;
  logic [DATA_WIDTH-1:0] in_b_dout;
  logic                  in_b_rd_en;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_wr_en;

  modport master (
    output in_a_empty, in_a_dout, in_b_empty, in_b_dout, out_full,
    input  in_a_rd_en, in_b_rd_en, out_din, out_wr_en
  );

  modport slave (
    input  in_a_empty, in_a_dout, in_b_empty, in_b_dout, out_full,
    output in_a_rd_en, in_b_rd_en, out_din, out_wr_en
  );
endinterface

// File: rtl/fixed_mult.sv
// Three-stage signed fixed-point multiplier (operands -> product -> dequantized result).
// Optional FIXED_MULT_SAT_EN clamps the result to the signed DATA_WIDTH range instead of wrapping.
module fixed_mult #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10
) (
  input  logic          clock,
  input  logic          reset,
  fixed_mult_if.slave   bus
);
  localparam int PW = 2 * DATA_WIDTH;

  logic                         v1_reg, v2_reg, v3_reg;
  logic signed [DATA_WIDTH-1:0] a_reg, b_reg, q_reg;
  logic signed [PW-1:0]         p_reg;

  logic                         adv1, adv2, adv3, take;
  logic signed [PW-1:0]         a_ext, b_ext, p_next;
  logic        [PW-1:0]         p_mag;
  logic signed [PW-1:0]         q_full, q_clamp;
  logic signed [DATA_WIDTH-1:0] q_next;
  logic                         unused_bits;

  assign adv3 = v3_reg & ~bus.out_full;
  assign adv2 = v2_reg & (~v3_reg | adv3);
  assign adv1 = v1_reg & (~v2_reg | adv2);
  // Gated by reset so no FIFO is popped while the pipeline is being cleared.
  assign take = reset & ~bus.in_a_empty & ~bus.in_b_empty & (~v1_reg | adv1);

  assign bus.in_a_rd_en = take;
  assign bus.in_b_rd_en = take;
  assign bus.out_wr_en  = adv3;
  assign bus.out_din    = q_reg;

  assign a_ext  = {{DATA_WIDTH{a_reg[DATA_WIDTH-1]}}, a_reg};
  assign b_ext  = {{DATA_WIDTH{b_reg[DATA_WIDTH-1]}}, b_reg};
  assign p_next = a_ext * b_ext;

  // Divide by 2**FRAC_BITS rounding toward zero: shift the magnitude, then restore the sign.
  always_comb begin
    p_mag  = '0;
    q_full = '0;
    if (p_reg[PW-1]) begin
      p_mag  = -p_reg;
      q_full = -(p_mag >> FRAC_BITS);
    end else begin
      q_full = p_reg >>> FRAC_BITS;
    end
  end

`ifdef FIXED_MULT_SAT_EN
  localparam logic signed [PW-1:0] Q_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] Q_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    q_clamp = q_full;
    if (q_full > Q_MAX) begin
      q_clamp = Q_MAX;
    end else if (q_full < Q_MIN) begin
      q_clamp = Q_MIN;
    end
  end
`else
  assign q_clamp = q_full;
`endif

  assign q_next      = q_clamp[DATA_WIDTH-1:0];
  assign unused_bits = ^q_clamp[PW-1:DATA_WIDTH];

  // Each stage loads when its predecessor advances, empties when it advances alone, else holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      p_reg  <= '0;
      q_reg  <= '0;
    end else begin
      if (take) begin
        a_reg  <= bus.in_a_dout;
        b_reg  <= bus.in_b_dout;
        v1_reg <= 1'b1;
      end else if (adv1) begin
        v1_reg <= 1'b0;
      end

      if (adv1) begin
        p_reg  <= p_next;
        v2_reg <= 1'b1;
      end else if (adv2) begin
        v2_reg <= 1'b0;
      end

      if (adv2) begin
        q_reg  <= q_next;
        v3_reg <= 1'b1;
      end else if (adv3) begin
        v3_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fixed_mult.sv
// Self-checking bench for fixed_mult: queue-backed FIFO models and an expected-result scoreboard.
module tb_fixed_mult;
  logic clock = 1'b0;
  logic reset;

  fixed_mult_if #(.DATA_WIDTH(32)) bus ();

  fixed_mult #(.DATA_WIDTH(32), .FRAC_BITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  logic [31:0] fa[$];
  logic [31:0] fb[$];
  logic [31:0] exp_q[$];
  int          wr_cycles[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          last_rd_cyc = 0;
  int          last_wr_cyc = 0;
  bit          rd_seen, wr_seen;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p / 1024;
`ifdef FIXED_MULT_SAT_EN
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
    return q[31:0];
  endfunction

  task automatic drive_fifo();
    bus.in_a_empty = (fa.size() == 0);
    bus.in_a_dout  = (fa.size() == 0) ? 32'h0 : fa[0];
    bus.in_b_empty = (fb.size() == 0);
    bus.in_b_dout  = (fb.size() == 0) ? 32'h0 : fb[0];
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    fa.push_back(a);
    fb.push_back(b);
    exp_q.push_back(e);
    drive_fifo();
  endtask

  // One clock cycle: observe at negedge, commit FIFO pops just after the posedge.
  task automatic step();
    logic [31:0] e;
    @(negedge clock);
    rd_seen = bus.in_a_rd_en;
    wr_seen = bus.out_wr_en;
    if (bus.in_a_rd_en !== bus.in_b_rd_en) begin
      fails++;
      $display("FAIL rd_en_pair: a=%b b=%b required equal", bus.in_a_rd_en, bus.in_b_rd_en);
    end
    if (rd_seen) begin
      rd_count++;
      last_rd_cyc = cyc;
    end
    if (wr_seen) begin
      wr_count++;
      last_wr_cyc = cyc;
      wr_cycles.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: out_din=%h required no write", bus.out_din);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_din !== e) begin
          fails++;
          $display("FAIL out_din: got %h required %h (cycle %0d)", bus.out_din, e, cyc);
        end else begin
          $display("[TB] write cycle %0d out_din=%h", cyc, bus.out_din);
        end
      end
    end
    @(posedge clock);
    #1;
    if (rd_seen) begin
      if (fa.size() > 0) void'(fa.pop_front());
      if (fb.size() > 0) void'(fb.pop_front());
    end
    cyc++;
    drive_fifo();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    fa.push_back(32'd1024);
    fb.push_back(32'd1024);
    drive_fifo();
    #1;
    tests++;
    if (bus.in_a_rd_en !== 1'b0 || bus.in_b_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_rd_en: got %b/%b required 0/0", bus.in_a_rd_en, bus.in_b_rd_en);
    end
    tests++;
    if (bus.out_wr_en !== 1'b0 || bus.out_din !== 32'h0) begin
      fails++;
      $display("FAIL reset_out: wr_en=%b din=%h required 0/0", bus.out_wr_en, bus.out_din);
    end
    fa.delete();
    fb.delete();
    drive_fifo();
    @(posedge clock);
    #1;
    reset = 1'b1;
    $display("[TB] reset state checked");
  endtask

  task automatic test_basic();
    push_pair(32'd3072, 32'd2048, 32'd6144);
    drain(20);
    tests++;
    if (last_wr_cyc - last_rd_cyc != 3) begin
      fails++;
      $display("FAIL latency: got %0d required 3", last_wr_cyc - last_rd_cyc);
    end
  endtask

  task automatic test_toward_zero();
    push_pair(32'hFFFF_FFFF, 32'd1, 32'd0);
    push_pair(-32'sd1536, 32'd1024, -32'sd1536);
    push_pair(-32'sd1537, 32'd1, 32'hFFFF_FFFF);
    drain(20);
  endtask

  task automatic test_back_to_back();
    wr_cycles.delete();
    for (int i = 0; i < 8; i++) push_pair(32'(i * 1024), 32'd1024, 32'(i * 1024));
    drain(40);
    tests++;
    if (wr_cycles.size() != 8) begin
      fails++;
      $display("FAIL b2b_count: got %0d required 8", wr_cycles.size());
    end else if (wr_cycles[7] - wr_cycles[0] != 7) begin
      fails++;
      $display("FAIL b2b_span: got %0d required 7", wr_cycles[7] - wr_cycles[0]);
    end
  endtask

  task automatic test_stall();
    int r0 = rd_count;
    int w0 = wr_count;
    logic [31:0] a;
    bus.out_full = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a = 32'(i * 3000);
      push_pair(a, 32'd512, model(a, 32'd512));
    end
    repeat (6) step();
    tests++;
    if (rd_count - r0 != 3) begin
      fails++;
      $display("FAIL stall_pops: got %0d required 3", rd_count - r0);
    end
    tests++;
    if (wr_count - w0 != 0) begin
      fails++;
      $display("FAIL stall_writes: got %0d required 0", wr_count - w0);
    end
    bus.out_full = 1'b0;
    drain(30);
    tests++;
    if (wr_count - w0 != 5) begin
      fails++;
      $display("FAIL stall_total: got %0d required 5", wr_count - w0);
    end
  endtask

  task automatic test_simultaneous();
    bus.out_full = 1'b1;
    for (int i = 1; i <= 3; i++) push_pair(32'(i * 1024), 32'd2048, 32'(i * 2048));
    repeat (4) step();
    push_pair(32'd5120, 32'd2048, 32'd10240);
    bus.out_full = 1'b0;
    step();
    tests++;
    if (!(rd_seen && wr_seen)) begin
      fails++;
      $display("FAIL simultaneous: rd=%b wr=%b required 1/1", rd_seen, wr_seen);
    end
    drain(20);
  endtask

  task automatic test_one_empty();
    int r0 = rd_count;
    fa.push_back(32'd5120);
    drive_fifo();
    repeat (4) step();
    tests++;
    if (rd_count - r0 != 0 || fa.size() != 1) begin
      fails++;
      $display("FAIL one_empty: pops=%0d a_left=%0d required 0/1", rd_count - r0, fa.size());
    end
    fb.push_back(32'd2048);
    exp_q.push_back(32'd10240);
    drive_fifo();
    drain(20);
  endtask

  task automatic test_wrap_sat();
`ifdef FIXED_MULT_SAT_EN
    push_pair(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    push_pair(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000);
    push_pair(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
`else
    push_pair(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFC0_0000);
    push_pair(32'h8000_0000, 32'h7FFF_FFFF, 32'h0020_0000);
    push_pair(32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
`endif
    drain(20);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int n = 0;
    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      b = (i % 2 == 0) ? 32'($urandom_range(0, 65535)) - 32'd32768 : $urandom();
      push_pair(a, b, model(a, b));
    end
    while (exp_q.size() > 0 && n < 400) begin
      bus.out_full = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    bus.out_full = 1'b0;
    drain(20);
  endtask

  task automatic test_reset_midflight();
    int w0;
    for (int i = 0; i < 4; i++) begin
      fa.push_back(32'd1024);
      fb.push_back(32'd4096);
    end
    drive_fifo();
    step();
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (bus.out_wr_en !== 1'b0 || bus.in_a_rd_en !== 1'b0 || bus.in_b_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL midflight_reset: wr=%b rd=%b/%b required 0/0/0",
               bus.out_wr_en, bus.in_a_rd_en, bus.in_b_rd_en);
    end
    fa.delete();
    fb.delete();
    drive_fifo();
    @(posedge clock);
    #1;
    reset = 1'b1;
    w0 = wr_count;
    repeat (8) step();
    tests++;
    if (wr_count - w0 != 0) begin
      fails++;
      $display("FAIL stale_writes: got %0d required 0", wr_count - w0);
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.out_full = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_toward_zero();
    test_back_to_back();
    test_stall();
    test_simultaneous();
    test_one_empty();
    test_wrap_sat();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
